fft_ctrl: RTL and testbench

Sequencer for the in-place radix-2 DIT FFT built around the two-port butterfly RAM. It runs three phases in order: bit-reversed loading of input samples, then log2(points) butterfly stages, then natural-order readout. For each phase it drives both RAM port addresses, the shared write enable, the twiddle ROM address and the datapath mux/strobe controls. It contains no data storage or arithmetic on samples.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_ctrl_if.sv | 32 +++
 rtl/fft_agu.sv | 28 ++
 rtl/fft_ctrl.sv | 153 +++++++++++++++
 tb/tb_fft_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT sequencer: state encoding,
// default transform size and the bit-reversal helper.
package fft_pkg;

    localparam int unsigned FFT_N = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BF_RD,
        BF_WR,
        UNLOAD
    } state_t;

    function automatic logic [FFT_N-1:0] bitrev(input logic [FFT_N-1:0] value,
                                                input int unsigned     width);
        logic [FFT_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < width && i < FFT_N; i++) begin
            r[i] = value[width - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// Control/handshake bundle between the FFT sequencer and the RAM, twiddle ROM
// and butterfly datapath.
interface fft_ctrl_if #(
    parameter int unsigned N = fft_pkg::FFT_N
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_ready;
    logic                 out_valid;
    logic [N-1:0]         add_a;
    logic [N-1:0]         add_b;
    logic                 we;
    logic                 load_sel;
    logic                 bf_latch;
    logic [N-2:0]         tw_addr;
    logic [$clog2(N)-1:0] stage;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, in_valid, out_ready,
        output in_ready, out_valid, add_a, add_b, we, load_sel, bf_latch,
               tw_addr, stage, busy, done
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, out_valid, add_a, add_b, we, load_sel, bf_latch,
               tw_addr, stage, busy, done
    );
endinterface

// File: rtl/fft_agu.sv
// Butterfly address generator: maps (stage, j) to the two operand addresses
// and the twiddle ROM index.
module fft_agu
    import fft_pkg::*;
#(
    parameter int unsigned N = FFT_N
) (
    input  logic [$clog2(N)-1:0] stage,
    input  logic [N-2:0]         j,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic [N-2:0]         tw_addr
);
    logic [N-1:0] jw;
    logic [N-1:0] half;
    logic [N-1:0] lo;

    always_comb begin
        jw      = {1'b0, j};
        half    = N'(1) << stage;
        lo      = jw & (half - N'(1));
        add_a   = ((jw >> stage) << (stage + 1'b1)) | lo;
        add_b   = add_a + half;
        // lo << (N-1-s) written as (lo << (N-1)) >> s so the shift never goes negative
        tw_addr = (N-1)'({lo[N-2:0], {(N-1){1'b0}}} >> stage);
    end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: bit-reversed load, log2(points)
// butterfly stages of read/write pairs, then natural-order readout.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N = FFT_N
) (
    input  logic       clk,
    input  logic       reset,
    fft_ctrl_if.master bus
);
    localparam int unsigned    SW         = $clog2(N);
    localparam logic [N:0]     CNT_LAST   = (N+1)'((1 << N) - 1);
    localparam logic [N:0]     CNT_ONE    = (N+1)'(1);
    localparam logic [N-2:0]   J_LAST     = '1;
    localparam logic [N-2:0]   J_ONE      = (N-1)'(1);
    localparam logic [SW-1:0]  STAGE_LAST = SW'(N - 1);
    localparam logic [SW-1:0]  STAGE_ONE  = SW'(1);

    state_t        state;
    logic [N:0]    cnt;
    logic [N-2:0]  j;
    logic [SW-1:0] stage;
    logic          busy_q, in_ready_q, out_valid_q, load_sel_q;
    logic          bf_latch_q, bf_wr_q, done_q;

    logic [N-1:0]  agu_a, agu_b, rev;
    logic [N-2:0]  agu_tw;

    fft_agu #(.N(N)) u_agu (
        .stage   (stage),
        .j       (j),
        .add_a   (agu_a),
        .add_b   (agu_b),
        .tw_addr (agu_tw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            j           <= '0;
            stage       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            load_sel_q  <= 1'b0;
            bf_latch_q  <= 1'b0;
            bf_wr_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // a start coinciding with the done pulse is dropped
                    if (bus.start && !done_q) begin
                        state      <= LOAD;
                        cnt        <= '0;
                        j          <= '0;
                        stage      <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        load_sel_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (cnt == CNT_LAST) begin
                            state      <= BF_RD;
                            cnt        <= '0;
                            in_ready_q <= 1'b0;
                            load_sel_q <= 1'b0;
                            bf_latch_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                BF_RD: begin
                    state      <= BF_WR;
                    bf_latch_q <= 1'b0;
                    bf_wr_q    <= 1'b1;
                end
                BF_WR: begin
                    bf_wr_q <= 1'b0;
                    if (j == J_LAST) begin
                        j     <= '0;
                        stage <= stage + STAGE_ONE;
                        if (stage == STAGE_LAST) begin
                            state       <= UNLOAD;
                            cnt         <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state      <= BF_RD;
                            bf_latch_q <= 1'b1;
                        end
                    end else begin
                        j          <= j + J_ONE;
                        state      <= BF_RD;
                        bf_latch_q <= 1'b1;
                    end
                end
                UNLOAD: begin
                    if (bus.out_ready) begin
                        if (cnt == CNT_LAST) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rev         = N'(bitrev(FFT_N'(cnt[N-1:0]), N));
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.tw_addr = '0;
        unique case (state)
            LOAD: begin
                bus.add_a = rev;
                bus.add_b = rev;
            end
            BF_RD, BF_WR: begin
                bus.add_a   = agu_a;
                bus.add_b   = agu_b;
                bus.tw_addr = agu_tw;
            end
            UNLOAD: begin
                bus.add_a = cnt[N-1:0];
                bus.add_b = cnt[N-1:0];
            end
            default: ;
        endcase
    end

    assign bus.we        = (in_ready_q & bus.in_valid) | bf_wr_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.load_sel  = load_sel_q;
    assign bus.bf_latch  = bf_latch_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = stage;

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl at N=9: load, compute, unload, start filtering
// and mid-transform reset.
module tb_fft_ctrl;
    localparam int unsigned N   = 9;
    localparam int          PTS = 512;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fft_ctrl_if #(.N(N)) bus();

    fft_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int brev9(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 9; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, c, nbf, nwe, s, jj, half, lo;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // reset values
        #12;
        chk("rst_busy",     bus.busy, 0);
        chk("rst_we",       bus.we, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid",bus.out_valid, 0);
        chk("rst_done",     bus.done, 0);
        chk("rst_add_a",    bus.add_a, 0);
        chk("rst_add_b",    bus.add_b, 0);
        chk("rst_tw",       bus.tw_addr, 0);
        chk("rst_stage",    bus.stage, 0);
        chk("rst_bf_latch", bus.bf_latch, 0);
        chk("rst_load_sel", bus.load_sel, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // first transform: load with in_valid every other cycle, stray start
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        k = 0;
        c = 0;
        while (k < PTS && c < 3000) begin
            bus.in_valid = c[0];
            bus.start    = (c == 6);
            #4;
            chk("load_in_ready", bus.in_ready, 1);
            chk("load_sel",      bus.load_sel, 1);
            chk("load_we",       bus.we, bus.in_valid);
            if (bus.in_valid) begin
                chk("load_add_a", bus.add_a, brev9(k));
                chk("load_add_b", bus.add_b, brev9(k));
                if (k == 1) chk("load_k1", bus.add_a, 256);
                if (k == 3) chk("load_k3", bus.add_a, 384);
                k++;
            end
            cyc();
            c++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk("load_accepts", k, PTS);
        #4;
        chk("bf_entry_latch",    bus.bf_latch, 1);
        chk("bf_entry_in_ready", bus.in_ready, 0);

        // compute phase, sampled mid-cycle from the first BF_RD
        c = 0; nbf = 0; nwe = 0;
        while (!bus.out_valid && c < 6000) begin
            if (bus.bf_latch) begin
                s    = nbf / 256;
                jj   = nbf % 256;
                half = 1 << s;
                lo   = jj % half;
                chk("bf_add_a", bus.add_a, (jj / half) * 2 * half + lo);
                chk("bf_add_b", bus.add_b, (jj / half) * 2 * half + lo + half);
                chk("bf_tw",    bus.tw_addr, lo * (256 / half));
                chk("bf_stage", bus.stage, s);
                chk("bf_rd_we", bus.we, 0);
                if (nbf == 5) begin
                    chk("s0j5_a", bus.add_a, 10);
                    chk("s0j5_b", bus.add_b, 11);
                    chk("s0j5_tw", bus.tw_addr, 0);
                end
                if (nbf == 8 * 256 + 5) begin
                    chk("s8j5_a", bus.add_a, 5);
                    chk("s8j5_b", bus.add_b, 261);
                    chk("s8j5_tw", bus.tw_addr, 5);
                end
                nbf++;
            end
            if (bus.we) begin
                nwe++;
                chk("bf_we_distinct", bus.add_a != bus.add_b, 1);
            end
            cyc();
            #4;
            c++;
        end
        chk("compute_cycles", c, 4608);
        chk("compute_we",     nwe, 2304);
        chk("compute_rd",     nbf, 2304);
        chk("unload_valid0",  bus.out_valid, 1);
        chk("unload_addr0",   bus.add_a, 0);

        // stalled readout
        repeat (10) begin
            cyc();
            #4;
            chk("stall_addr",  bus.add_a, 0);
            chk("stall_valid", bus.out_valid, 1);
        end
        for (int idx = 0; idx < PTS; idx++) begin
            cyc();
            bus.out_ready = 1'b1;
            #4;
            chk("unload_add_a", bus.add_a, idx);
            chk("unload_add_b", bus.add_b, idx);
            chk("unload_valid", bus.out_valid, 1);
            chk("unload_done",  bus.done, 0);
        end
        cyc();
        bus.out_ready = 1'b0;
        bus.start     = 1'b1;
        #4;
        chk("done_pulse",     bus.done, 1);
        chk("done_busy",      bus.busy, 0);
        chk("done_out_valid", bus.out_valid, 0);
        cyc();
        #4;
        chk("done_once",      bus.done, 0);
        chk("start_ignored",  bus.busy, 0);
        cyc();
        bus.start = 1'b0;
        #4;
        chk("restart_busy",     bus.busy, 1);
        chk("restart_in_ready", bus.in_ready, 1);
        chk("restart_addr",     bus.add_a, 0);

        // second transform: continuous load, then reset inside stage 3 BF_WR
        for (int i = 0; i < PTS; i++) begin
            cyc();
            bus.in_valid = 1'b1;
            #4;
        end
        cyc();
        bus.in_valid = 1'b0;
        #4;
        c = 0;
        while (!(bus.stage == 3 && bus.we && !bus.in_ready) && c < 6000) begin
            cyc();
            #4;
            c++;
        end
        chk("bfwr3_stage", bus.stage, 3);
        chk("bfwr3_we",    bus.we, 1);
        reset = 1'b0;
        #1;
        chk("abort_busy",  bus.busy, 0);
        chk("abort_we",    bus.we, 0);
        chk("abort_stage", bus.stage, 0);
        chk("abort_latch", bus.bf_latch, 0);
        chk("abort_add_a", bus.add_a, 0);
        cyc();
        reset = 1'b1;
        cyc();
        bus.start = 1'b1;
        cyc();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        #4;
        chk("fresh_in_ready", bus.in_ready, 1);
        chk("fresh_addr0",    bus.add_a, 0);
        chk("fresh_we",       bus.we, 1);
        cyc();
        #4;
        chk("fresh_addr1",    bus.add_a, 256);
        bus.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
